cardinal_nic: RTL

CARDINAL_NIC -- requirements
Module: cardinal_nic

---
 rtl/cardinal_nic_pkg.sv | 17 +
 rtl/nic_channel_buffer.sv | 42 ++++
 rtl/cardinal_nic.sv | 99 +++++++++
 3 files changed

// File: rtl/cardinal_nic_pkg.sv
// Shared constants for the cardinal NIC: data width, processor register map
// and the bit positions used inside the status words.
package cardinal_nic_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int ADDR_WIDTH = 2;

  localparam logic [1:0] NIC_IN_BUF   = 2'b00;
  localparam logic [1:0] NIC_IN_STAT  = 2'b01;
  localparam logic [1:0] NIC_OUT_BUF  = 2'b10;
  localparam logic [1:0] NIC_OUT_STAT = 2'b11;

  // Positions counted from the numeric LSB, i.e. big-endian bits 63 and 62.
  localparam int STAT_FULL_BIT = 0;
  localparam int STAT_OVF_BIT  = 1;

endpackage

// File: rtl/nic_channel_buffer.sv
// Single-entry packet buffer with a full flag. The caller only asserts load
// when empty and unload when full, so the two never coincide.
module nic_channel_buffer #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             unload_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             full_q, full_d;

  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (load_i) begin
      data_d = data_i;
      full_d = 1'b1;
    end else if (unload_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign data_o = data_q;
  assign full_o = full_q;

endmodule

// File: rtl/cardinal_nic.sv
// Cardinal router NIC: processor register interface on one side, strobe/ready
// network channels on the other, each direction backed by a one-entry buffer.
module cardinal_nic
  import cardinal_nic_pkg::*;
#(
  parameter int DATA_WIDTH = cardinal_nic_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = cardinal_nic_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] d_in,
  output logic [DATA_WIDTH-1:0] d_out,
  input  logic                  nicEn,
  input  logic                  nicWrEn,
  input  logic                  net_si,
  output logic                  net_ri,
  input  logic [DATA_WIDTH-1:0] net_di,
  output logic                  net_so,
  input  logic                  net_ro,
  output logic [DATA_WIDTH-1:0] net_do,
  input  logic                  net_polarity
);

  logic                  rd_en, wr_en;
  logic                  in_load, in_unload, in_full;
  logic                  out_load, out_unload, out_full;
  logic [DATA_WIDTH-1:0] in_buf, out_buf;
  logic                  out_ovf_q, out_ovf_d;
  logic                  wr_out_buf;

  assign rd_en      = nicEn & ~nicWrEn;
  assign wr_en      = nicEn & nicWrEn;
  assign wr_out_buf = wr_en & (addr == ADDR_WIDTH'(NIC_OUT_BUF));

  assign net_ri    = ~in_full;
  assign in_load   = net_si & ~in_full;
  assign in_unload = rd_en & (addr == ADDR_WIDTH'(NIC_IN_BUF)) & in_full;

  // Bus bit 0 is the MSB, so the virtual-channel tag sits at the top index.
  assign net_so     = out_full & net_ro & (out_buf[DATA_WIDTH-1] == net_polarity);
  assign out_load   = wr_out_buf & ~out_full;
  assign out_unload = net_so;
  assign net_do     = out_buf;

  nic_channel_buffer #(.WIDTH(DATA_WIDTH)) u_in_buf (
    .clk      (clk),
    .reset    (reset),
    .load_i   (in_load),
    .data_i   (net_di),
    .unload_i (in_unload),
    .data_o   (in_buf),
    .full_o   (in_full)
  );

  nic_channel_buffer #(.WIDTH(DATA_WIDTH)) u_out_buf (
    .clk      (clk),
    .reset    (reset),
    .load_i   (out_load),
    .data_i   (d_in),
    .unload_i (out_unload),
    .data_o   (out_buf),
    .full_o   (out_full)
  );

  always_comb begin
    out_ovf_d = out_ovf_q;
    if (rd_en && addr == ADDR_WIDTH'(NIC_OUT_STAT)) begin
      out_ovf_d = 1'b0;
    end
    if (wr_out_buf && out_full) begin
      out_ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_ovf_q <= 1'b0;
    end else begin
      out_ovf_q <= out_ovf_d;
    end
  end

  always_comb begin
    d_out = '0;
    if (rd_en) begin
      case (addr)
        ADDR_WIDTH'(NIC_IN_BUF):  d_out = in_buf;
        ADDR_WIDTH'(NIC_IN_STAT): d_out[STAT_FULL_BIT] = in_full;
        ADDR_WIDTH'(NIC_OUT_STAT): begin
          d_out[STAT_FULL_BIT] = out_full;
          d_out[STAT_OVF_BIT]  = out_ovf_q;
        end
        default: d_out = '0;
      endcase
    end
  end

endmodule
